// File: rtl/phys_reg_free_list_ckpt_pkg.sv
// Shared sizing constants and types for the checkpointed physical-register free list.
package phys_reg_free_list_ckpt_pkg;

  // Default configuration: 64 physical registers, 32 mapped at reset, 4 checkpoint columns.
  localparam int FREE_LIST_DEPTH      = 64;
  localparam int RESET_MAPPED_REGS    = 32;
  localparam int CKPT_COLUMNS         = 4;

  localparam int LOG_FREE_LIST_DEPTH  = $clog2(FREE_LIST_DEPTH);
  localparam int LOG_CKPT_COLUMNS     = $clog2(CKPT_COLUMNS);
  localparam int PHYS_REG_WIDTH       = LOG_FREE_LIST_DEPTH;

  typedef logic [PHYS_REG_WIDTH-1:0]      phys_reg_tag_t;
  // Extra msb separates a full list from an empty one.
  typedef logic [LOG_FREE_LIST_DEPTH:0]   free_list_ptr_t;
  typedef logic [LOG_CKPT_COLUMNS-1:0]    checkpoint_column_t;

  typedef struct packed {
    logic           valid;
    logic           resolved;
    free_list_ptr_t saved_head;
  } checkpoint_entry_t;

endpackage

// File: rtl/phys_reg_free_list_ckpt_if.sv
// Rename/commit/branch-unit side signals of the free list, bundled as one interface.
interface phys_reg_free_list_ckpt_if
  import phys_reg_free_list_ckpt_pkg::*;
#(
  parameter int TAG_W = PHYS_REG_WIDTH,
  parameter int COL_W = LOG_CKPT_COLUMNS,
  parameter int CNT_W = LOG_FREE_LIST_DEPTH + 1
);

  logic             dequeue_valid;
  logic             dequeue_ready;
  logic [TAG_W-1:0] dequeue_phys_reg_tag;
  logic             enqueue_valid;
  logic [TAG_W-1:0] enqueue_phys_reg_tag;
  logic             enqueue_ready;
  logic             save_valid;
  logic             save_ready;
  logic [COL_W-1:0] save_column;
  logic             restore_valid;
  logic [COL_W-1:0] restore_column;
  logic             clear_valid;
  logic [COL_W-1:0] clear_column;
  logic [CNT_W-1:0] free_count;

  // Pipeline side: rename, commit and the branch unit.
  modport master (
    output dequeue_valid, enqueue_valid, enqueue_phys_reg_tag,
           save_valid, restore_valid, restore_column, clear_valid, clear_column,
    input  dequeue_ready, dequeue_phys_reg_tag, enqueue_ready,
           save_ready, save_column, free_count
  );

  // Free-list side.
  modport slave (
    input  dequeue_valid, enqueue_valid, enqueue_phys_reg_tag,
           save_valid, restore_valid, restore_column, clear_valid, clear_column,
    output dequeue_ready, dequeue_phys_reg_tag, enqueue_ready,
           save_ready, save_column, free_count
  );

endinterface

// File: rtl/phys_reg_free_list_ckpt_checkpoint_table.sv
// Checkpoint column FIFO: saves free-list head pointers at branch dispatch,
// retires resolved columns oldest-first, and restores on mispredict.
module phys_reg_free_list_ckpt_checkpoint_table #(
  parameter int PTR_W   = 7,
  parameter int COLUMNS = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       i_save_valid,
  input  logic [PTR_W-1:0]           i_save_head,
  input  logic                       i_clear_valid,
  input  logic [$clog2(COLUMNS)-1:0] i_clear_column,
  input  logic                       i_restore_valid,
  input  logic [$clog2(COLUMNS)-1:0] i_restore_column,
  output logic                       o_save_ready,
  output logic [$clog2(COLUMNS)-1:0] o_save_column,
  output logic                       o_restore_fire,
  output logic [PTR_W-1:0]           o_restore_head
);

  localparam int LOG_COLS = $clog2(COLUMNS);
  typedef logic [LOG_COLS-1:0] col_t;

  typedef struct packed {
    logic             valid;
    logic             resolved;
    logic [PTR_W-1:0] saved_head;
  } entry_t;

  entry_t       r_cols [COLUMNS];
  col_t         r_col_head;
  col_t         r_col_tail;
  logic [COLUMNS-1:0] w_kill;
  logic         w_restore_fire;
  logic         w_save_ready;
  logic         w_save_fire;
  logic         w_retire;

  assign w_restore_fire = i_restore_valid && r_cols[i_restore_column].valid;
  assign w_save_ready   = !((r_col_tail == r_col_head) && r_cols[r_col_head].valid);
  assign w_save_fire    = i_save_valid && w_save_ready && !w_restore_fire;

  // Mark the restored column and every younger one; age is distance from the oldest column.
  always_comb begin
    // NOTE: default every bit first so no path leaves w_kill unassigned (avoids a latch).
    w_kill = '0;
    for (int i = 0; i < COLUMNS; i++) begin
      if (w_restore_fire && r_cols[i].valid &&
          (col_t'(col_t'(i) - r_col_head) >= col_t'(i_restore_column - r_col_head))) begin
        w_kill[i] = 1'b1;
      end
    end
  end

  // The oldest column leaves once resolved, unless a restore is wiping it this cycle.
  assign w_retire = r_cols[r_col_head].valid && r_cols[r_col_head].resolved && !w_kill[r_col_head];

  // Per-column state: restore kill beats retire beats save beats clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < COLUMNS; i++) r_cols[i] <= '0;
    end else begin
      for (int i = 0; i < COLUMNS; i++) begin
        if (w_kill[i]) begin
          r_cols[i].valid <= 1'b0;
        end else if (w_retire && (col_t'(i) == r_col_head)) begin
          r_cols[i].valid <= 1'b0;
        end else if (w_save_fire && (col_t'(i) == r_col_tail)) begin
          r_cols[i] <= '{valid: 1'b1, resolved: 1'b0, saved_head: i_save_head};
        end else if (i_clear_valid && (col_t'(i) == i_clear_column) && r_cols[i].valid) begin
          r_cols[i].resolved <= 1'b1;
        end
      end
    end
  end

  // Column FIFO pointers: tail rewinds to the restored column, head follows retirement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_col_head <= '0;
      r_col_tail <= '0;
    end else begin
      if (w_retire)            r_col_head <= r_col_head + col_t'(1);
      if (w_restore_fire)      r_col_tail <= i_restore_column;
      else if (w_save_fire)    r_col_tail <= r_col_tail + col_t'(1);
    end
  end

  assign o_save_ready   = w_save_ready;
  assign o_save_column  = r_col_tail;
  assign o_restore_fire = w_restore_fire;
  assign o_restore_head = r_cols[i_restore_column].saved_head;

endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Checkpointed physical-register free list: circular FIFO of free tags with
// single-cycle head restore from the checkpoint table on mispredict.
module phys_reg_free_list_ckpt
  import phys_reg_free_list_ckpt_pkg::*;
#(
  parameter int NUM_PHYS_REGS      = FREE_LIST_DEPTH,
  parameter int NUM_ARCH_REGS      = RESET_MAPPED_REGS,
  parameter int CHECKPOINT_COLUMNS = CKPT_COLUMNS
) (
  input logic CLK,
  input logic RST,
  phys_reg_free_list_ckpt_if.slave bus
);

  localparam int LOG_DEPTH         = $clog2(NUM_PHYS_REGS);
  localparam int NUM_FREE_AT_RESET = NUM_PHYS_REGS - NUM_ARCH_REGS;

  typedef logic [LOG_DEPTH:0]   ptr_t;
  typedef logic [LOG_DEPTH-1:0] tag_t;

  tag_t r_ram [NUM_PHYS_REGS];
  ptr_t r_head;
  ptr_t r_tail;

  logic w_empty;
  logic w_full;
  logic w_deq_fire;
  logic w_enq_fire;
  logic w_restore_fire;
  ptr_t w_head_after_deq;
  ptr_t w_restore_head;

  assign w_empty          = (r_head == r_tail);
  assign w_full           = (r_head[LOG_DEPTH-1:0] == r_tail[LOG_DEPTH-1:0]) &&
                            (r_head[LOG_DEPTH] != r_tail[LOG_DEPTH]);
  // A restore moves head itself, so a same-cycle dequeue is dropped.
  assign w_deq_fire       = bus.dequeue_valid && !w_empty && !w_restore_fire;
  assign w_enq_fire       = bus.enqueue_valid && !w_full;
  assign w_head_after_deq = w_deq_fire ? r_head + ptr_t'(1) : r_head;

  // Tag storage: preloaded with the unmapped tags, written at tail on commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the RAM is reset because its reset contents are the initial free tags, not don't-cares.
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        r_ram[i] <= (i < NUM_FREE_AT_RESET) ? tag_t'(NUM_ARCH_REGS + i) : '0;
      end
    end else if (w_enq_fire) begin
      r_ram[r_tail[LOG_DEPTH-1:0]] <= bus.enqueue_phys_reg_tag;
    end
  end

  // Head/tail pointers; restore overrides the dequeue, enqueue is independent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head <= '0;
      r_tail <= ptr_t'(NUM_FREE_AT_RESET);
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, like real flops.
      r_head <= w_restore_fire ? w_restore_head : w_head_after_deq;
      if (w_enq_fire) r_tail <= r_tail + ptr_t'(1);
    end
  end

  phys_reg_free_list_ckpt_checkpoint_table #(
    .PTR_W   (LOG_DEPTH + 1),
    .COLUMNS (CHECKPOINT_COLUMNS)
  ) u_ckpt_table (
    .CLK              (CLK),
    .RST              (RST),
    .i_save_valid     (bus.save_valid),
    .i_save_head      (w_head_after_deq),
    .i_clear_valid    (bus.clear_valid),
    .i_clear_column   (bus.clear_column),
    .i_restore_valid  (bus.restore_valid),
    .i_restore_column (bus.restore_column),
    .o_save_ready     (bus.save_ready),
    .o_save_column    (bus.save_column),
    .o_restore_fire   (w_restore_fire),
    .o_restore_head   (w_restore_head)
  );

  assign bus.dequeue_ready        = !w_empty;
  assign bus.dequeue_phys_reg_tag = r_ram[r_head[LOG_DEPTH-1:0]];
  assign bus.enqueue_ready        = !w_full;
  assign bus.free_count           = r_tail - r_head;

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Bench for the checkpointed free list: directed scenarios plus random traffic
// checked against a queue-based model of free tags and live checkpoints.
module tb_phys_reg_free_list_ckpt;
  import phys_reg_free_list_ckpt_pkg::*;

  localparam int NPR  = FREE_LIST_DEPTH;
  localparam int NCOL = CKPT_COLUMNS;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  phys_reg_free_list_ckpt_if bus ();

  phys_reg_free_list_ckpt dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: free tags in allocation order, the log of allocated tags, and live checkpoints
  // (oldest first), each remembering how many tags had been allocated when it was taken.
  typedef struct {
    int col;
    int saved;
    bit resolved;
  } mcol_t;

  int    fl[$];
  int    dq_log[$];
  mcol_t cq[$];
  int    m_col_tail;

  task automatic check(input string name, input logic [31:0] obs, input int exp);
    n_tests++;
    assert (obs === 32'(exp))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl = {};
    dq_log = {};
    cq = {};
    m_col_tail = 0;
    for (int t = RESET_MAPPED_REGS; t < NPR; t++) fl.push_back(t);
  endtask

  task automatic idle_inputs();
    bus.dequeue_valid = 1'b0;
    bus.enqueue_valid = 1'b0;
    bus.enqueue_phys_reg_tag = '0;
    bus.save_valid = 1'b0;
    bus.restore_valid = 1'b0;
    bus.restore_column = '0;
    bus.clear_valid = 1'b0;
    bus.clear_column = '0;
  endtask

  task automatic compare_model();
    check("dequeue_ready", bus.dequeue_ready, int'(fl.size() > 0));
    if (fl.size() > 0) check("dequeue_tag", bus.dequeue_phys_reg_tag, fl[0]);
    check("enqueue_ready", bus.enqueue_ready, int'(fl.size() < NPR));
    check("free_count", bus.free_count, fl.size());
    check("save_ready", bus.save_ready, int'(cq.size() < NCOL));
    check("save_column", bus.save_column, m_col_tail);
  endtask

  // Enqueue only tags whose slot cannot collide with tags a restore may bring back.
  function automatic bit enq_legal();
    int k;
    k = dq_log.size() - ((cq.size() > 0) ? cq[0].saved : dq_log.size());
    return (fl.size() + k) < NPR;
  endfunction

  // Drive one cycle of requests (called at a falling edge) and advance the model.
  task automatic apply(input bit deq, input bit enq, input int etag, input bit sv,
                       input bit rs, input int rcol, input bit cl, input int ccol);
    int  rpos;
    bit  retire, deq_fire, enq_fire, save_fire;
    bus.dequeue_valid        = deq;
    bus.enqueue_valid        = enq;
    bus.enqueue_phys_reg_tag = phys_reg_tag_t'(etag);
    bus.save_valid           = sv;
    bus.restore_valid        = rs;
    bus.restore_column       = checkpoint_column_t'(rcol);
    bus.clear_valid          = cl;
    bus.clear_column         = checkpoint_column_t'(ccol);

    rpos = -1;
    if (rs) for (int p = 0; p < cq.size(); p++) if (cq[p].col == rcol) rpos = p;
    retire    = (cq.size() > 0) && cq[0].resolved && (rpos != 0);
    deq_fire  = deq && (fl.size() > 0) && (rpos < 0);
    enq_fire  = enq && (fl.size() < NPR);
    save_fire = sv && (cq.size() < NCOL) && (rpos < 0);

    if (rpos >= 0) begin
      int s;
      s = cq[rpos].saved;
      while (cq.size() > rpos) void'(cq.pop_back());
      for (int p = dq_log.size() - 1; p >= s; p--) fl.push_front(dq_log[p]);
      while (dq_log.size() > s) void'(dq_log.pop_back());
      m_col_tail = rcol;
    end
    if (cl) for (int p = 0; p < cq.size(); p++) if (cq[p].col == ccol) cq[p].resolved = 1'b1;
    if (retire) void'(cq.pop_front());
    if (deq_fire) dq_log.push_back(fl.pop_front());
    if (enq_fire) fl.push_back(etag);
    if (save_fire) begin
      cq.push_back('{col: m_col_tail, saved: dq_log.size(), resolved: 1'b0});
      m_col_tail = (m_col_tail + 1) % NCOL;
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
    compare_model();
  endtask

  task automatic step(input bit deq, input bit enq, input int etag, input bit sv,
                      input bit rs, input int rcol, input bit cl, input int ccol);
    apply(deq, enq, etag, sv, rs, rcol, cl, ccol);
    advance();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    compare_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reset values.
    check("rst_dequeue_ready", bus.dequeue_ready, 1);
    check("rst_dequeue_tag", bus.dequeue_phys_reg_tag, 32);
    check("rst_enqueue_ready", bus.enqueue_ready, 1);
    check("rst_save_ready", bus.save_ready, 1);
    check("rst_save_column", bus.save_column, 0);
    check("rst_free_count", bus.free_count, 32);

    // Drain: tags 32..63 in order, then empty; a dequeue on empty changes nothing.
    for (int i = 0; i < 32; i++) begin
      check("drain_tag", bus.dequeue_phys_reg_tag, 32 + i);
      step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    check("drain_ready", bus.dequeue_ready, 0);
    check("drain_count", bus.free_count, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("empty_deq_count", bus.free_count, 0);

    // Enqueue into empty list: no same-cycle bypass.
    apply(0, 1, 5, 0, 0, 0, 0, 0);
    #1 check("no_bypass_ready", bus.dequeue_ready, 0);
    advance();
    check("enq5_ready", bus.dequeue_ready, 1);
    check("enq5_tag", bus.dequeue_phys_reg_tag, 5);

    // Save after two dequeues, dequeue three more, restore.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("save0_next_column", bus.save_column, 1);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check("restore0_tag", bus.dequeue_phys_reg_tag, 34);
    check("restore0_count", bus.free_count, 30);
    check("restore0_col", bus.save_column, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);  // column 0 now invalid: restore ignored, dequeue proceeds
    check("restore_invalid_count", bus.free_count, 29);
    check("restore_invalid_tag", bus.dequeue_phys_reg_tag, 35);

    // Fill every column, release two out of order.
    do_reset();
    repeat (4) step(0, 0, 0, 1, 0, 0, 0, 0);
    check("cols_full", bus.save_ready, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("cols_still_full", bus.save_ready, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("col0_retired", bus.save_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("cols_refilled", bus.save_ready, 0);

    // Restore a middle column; same-cycle dequeue and save are dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    check("pre_restore_count", bus.free_count, 29);
    step(1, 0, 0, 1, 1, 1, 0, 0);
    check("restore1_count", bus.free_count, 31);
    check("restore1_tag", bus.dequeue_phys_reg_tag, 33);
    check("restore1_col", bus.save_column, 1);
    step(1, 0, 0, 0, 1, 2, 0, 0);
    check("restore2_ignored", bus.free_count, 30);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check("restore_col0_count", bus.free_count, 32);
    check("restore_col0_tag", bus.dequeue_phys_reg_tag, 32);

    // Fill to full; enqueue while full is ignored.
    do_reset();
    for (int i = 0; i < 32; i++) step(0, 1, i, 0, 0, 0, 0, 0);
    check("full_enqueue_ready", bus.enqueue_ready, 0);
    check("full_count", bus.free_count, 64);
    step(0, 1, 9, 0, 0, 0, 0, 0);
    check("full_enq_ignored", bus.free_count, 64);

    // 64 simultaneous enqueue/dequeue pairs across the pointer wrap.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1, 1, (i * 5 + 3) % 64, 0, 0, 0, 0, 0);
      check("wrap_count", bus.free_count, 32);
    end

    // Random traffic against the model, with an asynchronous reset midway.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit deq, enq, sv, rs, cl;
      deq = ($urandom_range(0, 99) < 50);
      enq = ($urandom_range(0, 99) < 50) && enq_legal();
      sv  = ($urandom_range(0, 99) < 20);
      rs  = ($urandom_range(0, 99) < 6);
      cl  = ($urandom_range(0, 99) < 30);
      step(deq, enq, int'($urandom_range(0, NPR - 1)), sv, rs, int'($urandom_range(0, NCOL - 1)),
           cl, int'($urandom_range(0, NCOL - 1)));
      if (i == 1500) begin
        #2 RST = 1'b1;
        #1;
        check("midrst_count", bus.free_count, 32);
        check("midrst_tag", bus.dequeue_phys_reg_tag, 32);
        check("midrst_save_column", bus.save_column, 0);
        check("midrst_save_ready", bus.save_ready, 1);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        compare_model();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
